// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution front end and its ALU.
package conv_pkg;

    localparam int PIX_W = 8;    // pixel and coefficient width
    localparam int K     = 3;    // kernel edge
    localparam int NCOEF = 9;    // K*K coefficients
    localparam int ACC_W = 20;   // ALU accumulator width

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_COEF = 3'd1,
        FILL      = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels: combinational read, synchronous write, same address.
// Contents are never reset; every location is rewritten before it is read.
module line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [IMG_W];

    // Read returns the old value in the write cycle (read-before-write).
    assign rdata = mem[addr];

    // Row storage update on pixel acceptance.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Coefficient loader, two-row line buffer and 3x3 window generator feeding
// the convolution ALU. One alu_en pulse per unpadded output position.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PIX_W-1:0]       coef_in,
    input  logic                   coef_valid,
    output logic                   coef_ready,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [NCOEF*PIX_W-1:0] filter,
    output logic [K*PIX_W-1:0]     line1,
    output logic [K*PIX_W-1:0]     line2,
    output logic [K*PIX_W-1:0]     line3,
    output logic                   alu_en,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    // One spare bit: row steps to IMG_H on the final pixel of the frame.
    localparam int RW = $clog2(IMG_H) + 1;

    state_t            state;
    logic [3:0]        coef_idx;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [PIX_W-1:0]  lb0_rd, lb1_rd;

    // Only the two older columns are stored; the newest column is the live
    // line-buffer read / pixel, so the window is {live, sr}.
    logic [2*PIX_W-1:0] sr_top, sr_mid, sr_bot;

    logic coef_acc, pix_acc, win_hit, last_pix, frame_start;

    assign coef_ready  = (state == LOAD_COEF);
    assign pix_ready   = (state == FILL) || (state == RUN);
    assign busy        = (state != IDLE);

    assign coef_acc    = coef_valid && coef_ready;
    assign pix_acc     = pix_valid && pix_ready;
    assign frame_start = (state == IDLE) && start;
    assign win_hit     = pix_acc && (row >= RW'(2)) && (col >= CW'(2));
    assign last_pix    = pix_acc && (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));

    // Frame sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (start) state <= LOAD_COEF;
                LOAD_COEF: if (coef_acc && coef_idx == 4'(NCOEF-1)) state <= FILL;
                FILL:      if (pix_acc && row == RW'(2)) state <= RUN;
                RUN:       if (last_pix) state <= DONE;
                DONE:      state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Coefficient capture, byte k of filter on beat k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filter   <= '0;
            coef_idx <= '0;
        end else if (frame_start) begin
            coef_idx <= '0;
        end else if (coef_acc) begin
            filter[coef_idx*PIX_W +: PIX_W] <= coef_in;
            coef_idx                        <= coef_idx + 4'd1;
        end
    end

    // Raster position of the next pixel; advances only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end else if (pix_acc) begin
            if (col == CW'(IMG_W-1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // LB0 holds row r-1, LB1 holds row r-2; on acceptance the column
    // moves down one buffer and the new pixel enters LB0.
    line_buffer #(.IMG_W(IMG_W), .AW(CW)) u_lb0 (
        .clk   (clk),
        .we    (pix_acc),
        .addr  (col),
        .wdata (pix_in),
        .rdata (lb0_rd)
    );

    line_buffer #(.IMG_W(IMG_W), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (pix_acc),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Column shift registers: newest column enters at the top byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_top <= '0;
            sr_mid <= '0;
            sr_bot <= '0;
        end else if (pix_acc) begin
            sr_top <= {lb1_rd, sr_top[2*PIX_W-1:PIX_W]};
            sr_mid <= {lb0_rd, sr_mid[2*PIX_W-1:PIX_W]};
            sr_bot <= {pix_in, sr_bot[2*PIX_W-1:PIX_W]};
        end
    end

    // Window presentation; columns 0-1 and rows 0-1 never emit, which keeps
    // stale columns from the previous row out of every window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_en <= 1'b0;
            line1  <= '0;
            line2  <= '0;
            line3  <= '0;
        end else begin
            alu_en <= win_hit;
            if (win_hit) begin
                line1 <= {lb1_rd, sr_top};
                line2 <= {lb0_rd, sr_mid};
                line3 <= {pix_in, sr_bot};
            end
        end
    end

    // End-of-frame pulse lands the cycle after the last window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= (state == DONE);
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench: a 4x4 feeder and a 5x3 feeder share data/valid inputs and
// reset but have separate start strobes, so only one is active at a time.
module tb_conv_window_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic [7:0]  coef_in, pix_in;
    logic        coef_valid, pix_valid;

    logic        cr1, pr1, en1, busy1, fd1;
    logic [71:0] filt1;
    logic [23:0] la1, lb1, lc1;
    logic        cr2, pr2, en2, busy2, fd2;
    logic [71:0] filt2;
    logic [23:0] la2, lb2, lc2;

    int errors = 0;
    int checks = 0;

    logic [71:0] wq1[$];
    logic [71:0] wq2[$];
    int stall_viol = 0;
    int fd_cnt1 = 0, fd_bad1 = 0, fd_cnt2 = 0;
    bit pv_prev = 1'b0, en1_prev = 1'b0;

    always #5 clk = ~clk;

    conv_window_feeder #(.IMG_W(4), .IMG_H(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(cr1),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr1),
        .filter(filt1), .line1(la1), .line2(lb1), .line3(lc1),
        .alu_en(en1), .busy(busy1), .frame_done(fd1)
    );

    conv_window_feeder #(.IMG_W(5), .IMG_H(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(cr2),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr2),
        .filter(filt2), .line1(la2), .line2(lb2), .line3(lc2),
        .alu_en(en2), .busy(busy2), .frame_done(fd2)
    );

    // Window recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (en1) begin
            wq1.push_back({la1, lb1, lc1});
            if (!pv_prev) stall_viol++;
        end
        if (en2) wq2.push_back({la2, lb2, lc2});
        if (fd1) begin
            fd_cnt1++;
            if (!en1_prev || busy1) fd_bad1++;
        end
        if (fd2) fd_cnt2++;
        pv_prev  = pix_valid;
        en1_prev = en1;
    end

    function automatic logic [7:0] pv(int w, int r, int c, bit hex);
        return hex ? 8'(16*r + c) : 8'(w*r + c);
    endfunction

    // Expected 3x3 window centred one row/col up-left of (r,c); left column in the low byte.
    function automatic logic [71:0] exp_win(int w, int r, int c, bit hex);
        logic [71:0] x;
        x = '0;
        for (int i = 0; i < 3; i++)
            x[71-24*i -: 24] = {pv(w, r-2+i, c, hex), pv(w, r-2+i, c-1, hex), pv(w, r-2+i, c-2, hex)};
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit sel);
        int n;
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            coef_valid = 1'b1;
            coef_in    = 8'(k + 1);
            n = 0;
            while (!(sel ? cr2 : cr1) && n < 20) begin tick(); n++; end
            if (n >= 20) begin
                checks++; errors++;
                $display("FAIL coef_ready_timeout: beat %0d never accepted", k);
            end
            tick();
        end
        coef_valid = 1'b0;
    endtask

    task automatic send_pix(input bit sel, input logic [7:0] v, input bit stall);
        int n;
        if (stall) begin pix_valid = 1'b0; tick(); end
        pix_valid = 1'b1;
        pix_in    = v;
        n = 0;
        while (!(sel ? pr2 : pr1) && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL pix_ready_timeout: pixel %02h never accepted", v);
        end
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input int w, input int h, input bit hex, input bit stalls);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                send_pix(sel, pv(w, r, c, hex), stalls ? ($urandom_range(0, 1) == 1) : 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 0; start2 = 0; coef_valid = 0; pix_valid = 0; coef_in = 0; pix_in = 0;
        repeat (2) tick();
        checks++;
        if ({filt1, la1, lb1, lc1, en1, busy1, fd1, cr1, pr1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: outputs %h want 0", {filt1, la1, lb1, lc1, en1, busy1, fd1, cr1, pr1});
        end
        checks++;
        if ({filt2, en2, busy2, fd2, cr2, pr2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: outputs %h want 0", {filt2, en2, busy2, fd2, cr2, pr2});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_coef_load();
        start_frame(0);
        checks++;
        if (filt1 !== 72'h090807060504030201) begin
            errors++; $display("FAIL coef_filter: got %h want 090807060504030201", filt1);
        end
        checks++;
        if (cr1 !== 1'b0) begin errors++; $display("FAIL coef_ready_drop: got %b want 0", cr1); end
        checks++;
        if (pr1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++; $display("FAIL coef_to_fill: pix_ready=%b busy=%b want 1 1", pr1, busy1);
        end
        send_frame(0, 4, 4, 0, 0);
    endtask

    task automatic test_ramp_frame();
        int base, fdb, fbb;
        logic [71:0] got;
        base = wq1.size(); fdb = fd_cnt1; fbb = fd_bad1;
        start_frame(0);
        send_frame(0, 4, 4, 0, 0);
        checks++;
        if (wq1.size() - base != 4) begin
            errors++; $display("FAIL ramp_count: got %0d want 4", wq1.size() - base);
        end
        got = (wq1.size() > base) ? wq1[base] : 'x;
        checks++;
        if (got !== {24'h020100, 24'h060504, 24'h0A0908}) begin
            errors++; $display("FAIL ramp_first: got %h want 0201000605040A0908", got);
        end
        got = (wq1.size() > base + 3) ? wq1[base+3] : 'x;
        checks++;
        if (got !== {24'h070605, 24'h0B0A09, 24'h0F0E0D}) begin
            errors++; $display("FAIL ramp_last: got %h want 0706050B0A090F0E0D", got);
        end
        checks++;
        if (fd_cnt1 - fdb != 1 || fd_bad1 != fbb) begin
            errors++; $display("FAIL ramp_frame_done: pulses %0d misplaced %0d want 1 0", fd_cnt1 - fdb, fd_bad1 - fbb);
        end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL ramp_idle: busy=%b want 0", busy1); end
    endtask

    task automatic test_stalls();
        int base, sv;
        logic [71:0] got;
        base = wq1.size(); sv = stall_viol;
        start_frame(0);
        send_frame(0, 4, 4, 0, 1);
        checks++;
        if (wq1.size() - base != 4) begin
            errors++; $display("FAIL stall_count: got %0d want 4", wq1.size() - base);
        end
        for (int k = 0; k < 4; k++) begin
            got = (wq1.size() > base + k) ? wq1[base+k] : 'x;
            checks++;
            if (got !== exp_win(4, 2 + k/2, 2 + k%2, 0)) begin
                errors++; $display("FAIL stall_win%0d: got %h want %h", k, got, exp_win(4, 2 + k/2, 2 + k%2, 0));
            end
        end
        checks++;
        if (stall_viol != sv) begin
            errors++; $display("FAIL stall_alu_en: %0d pulses without a pixel, want 0", stall_viol - sv);
        end
    endtask

    task automatic test_row_wrap();
        int base, b1, fdb;
        logic [71:0] got;
        base = wq2.size(); b1 = wq1.size(); fdb = fd_cnt2;
        start_frame(1);
        send_frame(1, 5, 3, 1, 0);
        checks++;
        if (wq2.size() - base != 3 || wq1.size() != b1) begin
            errors++; $display("FAIL wrap_count: got %0d (4x4 unit %0d) want 3 (0)", wq2.size() - base, wq1.size() - b1);
        end
        for (int k = 0; k < 3; k++) begin
            got = (wq2.size() > base + k) ? wq2[base+k] : 'x;
            checks++;
            if (got !== exp_win(5, 2, 2 + k, 1)) begin
                errors++; $display("FAIL wrap_win%0d: got %h want %h", k, got, exp_win(5, 2, 2 + k, 1));
            end
            // Every byte of a window line must come from the same image row.
            checks++;
            if (got[71:68] !== got[63:60] || got[71:68] !== got[55:52] ||
                got[47:44] !== got[39:36] || got[47:44] !== got[31:28] ||
                got[23:20] !== got[15:12] || got[23:20] !== got[7:4]) begin
                errors++; $display("FAIL wrap_mixed_rows%0d: got %h want single row per line", k, got);
            end
        end
        checks++;
        if (fd_cnt2 - fdb != 1) begin errors++; $display("FAIL wrap_frame_done: got %0d want 1", fd_cnt2 - fdb); end
    endtask

    task automatic test_busy_start();
        int base;
        logic [71:0] got;
        base = wq1.size();
        start_frame(0);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start1 = 1'b1; coef_valid = 1'b1; coef_in = 8'hFF;
            end
            send_pix(0, pv(4, i/4, i%4, 0), 1'b0);
            start1 = 1'b0; coef_valid = 1'b0;
        end
        repeat (3) tick();
        checks++;
        if (wq1.size() - base != 4) begin
            errors++; $display("FAIL busy_start_count: got %0d want 4", wq1.size() - base);
        end
        for (int k = 0; k < 4; k++) begin
            got = (wq1.size() > base + k) ? wq1[base+k] : 'x;
            checks++;
            if (got !== exp_win(4, 2 + k/2, 2 + k%2, 0)) begin
                errors++; $display("FAIL busy_start_win%0d: got %h want %h", k, got, exp_win(4, 2 + k/2, 2 + k%2, 0));
            end
        end
        checks++;
        if (filt1 !== 72'h090807060504030201 || busy1 !== 1'b0) begin
            errors++; $display("FAIL busy_start_state: filter %h busy %b want 090807060504030201 0", filt1, busy1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        logic [71:0] got;
        start_frame(0);
        for (int i = 0; i < 6; i++) send_pix(0, pv(4, i/4, i%4, 0), 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({filt1, la1, lb1, lc1, en1, busy1, fd1, cr1, pr1} !== '0) begin
            errors++; $display("FAIL midreset_async: outputs %h want 0", {filt1, la1, lb1, lc1, en1, busy1, fd1, cr1, pr1});
        end
        tick();
        checks++;
        if ({busy1, pr1, cr1, en1} !== 4'b0) begin
            errors++; $display("FAIL midreset_idle: busy/pix_ready/coef_ready/alu_en %b want 0000", {busy1, pr1, cr1, en1});
        end
        rst = 1'b0;
        tick();
        base = wq1.size();
        start_frame(0);
        send_frame(0, 4, 4, 0, 0);
        checks++;
        if (wq1.size() - base != 4) begin
            errors++; $display("FAIL midreset_count: got %0d want 4", wq1.size() - base);
        end
        for (int k = 0; k < 4; k++) begin
            got = (wq1.size() > base + k) ? wq1[base+k] : 'x;
            checks++;
            if (got !== exp_win(4, 2 + k/2, 2 + k%2, 0)) begin
                errors++; $display("FAIL midreset_win%0d: got %h want %h", k, got, exp_win(4, 2 + k/2, 2 + k%2, 0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_coef_load();
        test_ramp_frame();
        test_stalls();
        test_row_wrap();
        test_busy_start();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Front end of the 3×3 convolution datapath: loads the nine filter coefficients, accepts a row-major 8-bit pixel stream, and buffers two image rows. Each time a full 3×3 window is available it presents `filter`, `line1`, `line2`, `line3` and a one-cycle `alu_en` to the convolution ALU, which consumes exactly this interface. One `alu_en` pulse is produced per valid (unpadded) output position.

## Interface

Parameters:
- `IMG_W`, default 32: image width in pixels; minimum 3.
- `IMG_H`, default 32: image height in rows; minimum 3.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a frame; ignored unless in IDLE.
- `coef_in` input 8: filter coefficient byte.
- `coef_valid` input 1: `coef_in` valid.
- `coef_ready` output 1: high only in LOAD_COEF.
- `pix_in` input 8: pixel byte.
- `pix_valid` input 1: `pix_in` valid.
- `pix_ready` output 1: high in FILL and RUN.
- `filter` output 72: coefficients; byte k at `[8k+7:8k]`, k = 0..8, row-major from the top-left.
- `line1` / `line2` / `line3` output 24 each: top / middle / bottom window row; `[7:0]` is the left column, `[23:16]` the right column.
- `alu_en` output 1: window valid, one cycle per window.
- `busy` output 1: state ≠ IDLE.
- `frame_done` output 1: one-cycle end-of-frame pulse.

## Operation

- States:
  - IDLE → LOAD_COEF on `start`.
  - LOAD_COEF → FILL after the 9th coefficient handshake.
  - FILL → RUN on the first accepted pixel at row 2.
  - RUN → DONE in the cycle the last window is emitted.
  - DONE → IDLE unconditionally.
- Coefficients:
  - Beat k (0..8) is written to `filter` byte k on `coef_valid && coef_ready`.
  - `filter` holds its value until the next LOAD_COEF.
- Pixel acceptance: `pix_valid && pix_ready`. Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on acceptance. At `col` = IMG_W-1, `col` wraps to 0 and `row` increments.
- Line buffers:
  - LB0 holds row r-1 and LB1 holds row r-2, each IMG_W×8.
  - On acceptance at column c: read LB0[c] and LB1[c] (old values), then write LB1[c] ← LB0[c] and LB0[c] ← pixel (read-before-write).
- Windowing: three 3-column shift registers (top = LB1 read, middle = LB0 read, bottom = pixel). Each shifts left on every acceptance; the newest value enters `[23:16]`.
- Window emission:
  - `alu_en` is registered high in the cycle after an acceptance with row ≥ 2 and col ≥ 2.
  - Otherwise `alu_en` is low, and `line1..3` hold their last values.
- Boundaries:
  - Columns 0–1 of each row emit nothing, so stale columns from the previous row never appear in a window.
  - Rows 0–1 only fill the buffers.
  - Windows per frame = (IMG_W-2)·(IMG_H-2).
- Stalls: with `pix_valid` low, no counter, buffer or shift register changes, and `alu_en` stays low.
- Simultaneous events: `start` while busy is ignored. `coef_valid` outside LOAD_COEF and `pix_valid` outside FILL/RUN are ignored.
- Reset (asynchronous, at any time including mid-frame):
  - State returns to IDLE; counters clear.
  - All outputs go to 0: `filter`, `line1..3`, `alu_en`, `busy`, `frame_done`, `coef_ready`, `pix_ready`.
  - Line buffer contents are not reset; they are always rewritten before use.

## Timing

- Latency: a pixel accepted at edge t completes its window, and `alu_en` is high in the cycle after t.
- Throughput: one pixel per cycle with `pix_valid` held high, giving back-to-back `alu_en` within a row.
- `frame_done` is high for exactly one cycle, the cycle after the final `alu_en`. `busy` falls in the same cycle.
- `coef_ready` and `pix_ready` are registered-state decodes; neither depends combinationally on `*_valid`.

## Structure

- `conv_pkg` contains:
  - the state enum (IDLE, LOAD_COEF, FILL, RUN, DONE);
  - the constants `PIX_W` = 8, `K` = 3, `NCOEF` = 9, and `ACC_W` = 20 (shared with the ALU).
- One sub-module, `line_buffer`: IMG_W×8 array with combinational read and synchronous write at the same address. It is instantiated twice (LB0, LB1).
- Counters, FSM and shift registers live in the top module.

## Test plan

- **Coefficient load:** reset, `start`, then coefficients 1..9 → `filter` = 72'h090807060504030201; `coef_ready` drops after beat 9.
- **Full frame, ramp image:** IMG_W = IMG_H = 4, pixel value = 4·row + col, streamed continuously → exactly 4 `alu_en` pulses.
  - First window: `line1` = 24'h020100, `line2` = 24'h060504, `line3` = 24'h0A0908.
  - Last window: `line1` = 24'h070605, `line2` = 24'h0B0A09, `line3` = 24'h0F0E0D.
  - `frame_done` is high the cycle after the 4th pulse.
- **Stalls:** same frame with `pix_valid` toggled randomly → identical window sequence; no `alu_en` during stalls.
- **Row wrap:** 5×3 image → 3 windows, all from row 2. No window contains a column-3/4 pixel paired with a column-0/1 pixel of another row.
- **Busy start:** `start` pulsed mid-frame → no effect; the window count is unchanged.
- **Reset mid-frame:** assert `rst` after 6 pixels → all outputs 0 and IDLE. A new `start` plus a full frame then yields the correct 4 windows.
